// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl
//   Multi-cycle divide controller for the EX stage (DIV / DIVU).
//   A start request latches the operand magnitudes and sign bits. The unit
//   then runs DATA_W restoring (trial-subtract) steps and applies the sign
//   fix-ups. The result is held, together with ready_o, until start_i drops.
//   A divisor of zero short-cuts to a zero result without iterating.
//
// Ports
//   clk           in   1          system clock, rising edge
//   rst           in   1          synchronous reset, active-high
//   signed_div_i  in   1          1 = DIV (two's complement), 0 = DIVU
//   opdata1_i     in   DATA_W     dividend
//   opdata2_i     in   DATA_W     divisor
//   start_i       in   1          request; held high until ready_o is seen
//   annul_i       in   1          pipeline flush: cancel or refuse an operation
//   result_o      out  2*DATA_W   {remainder, quotient}, registered
//   ready_o       out  1          result valid, registered
module div_seq_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int W = DATA_W;
  localparam logic [5:0] CNT_LAST = 6'(W);

  typedef enum logic [1:0] {
    ST_FREE   = 2'b00,
    ST_BYZERO = 2'b01,
    ST_ON     = 2'b10,
    ST_END    = 2'b11
  } state_t;

  // Two's complement negation when neg is set; used both for taking operand
  // magnitudes and for restoring the signs of quotient and remainder.
  function automatic logic [W-1:0] cond_neg(input logic neg, input logic [W-1:0] x);
    cond_neg = neg ? ((~x) + W'(1)) : x;
  endfunction

  state_t          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [2*W:0]    dvd_q, dvd_d;
  logic [W-1:0]    dsr_q, dsr_d;
  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            sgn_q, sgn_d;
  logic [2*W-1:0]  result_q, result_d;
  logic            ready_q, ready_d;

  logic [W:0]      diff;
  logic [W-1:0]    quot_fix;
  logic [W-1:0]    rem_fix;

  // Trial subtraction of the divisor from the top W+1 bits of the work reg;
  // a set MSB means the partial remainder was smaller than the divisor.
  assign diff     = dvd_q[2*W:W] - {1'b0, dsr_q};
  assign quot_fix = cond_neg(sgn_q & (s1_q ^ s2_q), dvd_q[W-1:0]);
  assign rem_fix  = cond_neg(sgn_q & s1_q, dvd_q[2*W:W+1]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    sgn_d    = sgn_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      ST_FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = ST_BYZERO;
          end else begin
            state_d = ST_ON;
            cnt_d   = 6'd0;
            dsr_d   = cond_neg(signed_div_i & opdata2_i[W-1], opdata2_i);
            dvd_d   = {{W{1'b0}}, cond_neg(signed_div_i & opdata1_i[W-1], opdata1_i), 1'b0};
            s1_d    = opdata1_i[W-1];
            s2_d    = opdata2_i[W-1];
            sgn_d   = signed_div_i;
          end
        end
      end

      ST_BYZERO: begin
        dvd_d    = '0;
        state_d  = ST_END;
        result_d = '0;
        ready_d  = 1'b1;
      end

      ST_ON: begin
        if (annul_i) begin
          // Flush has priority over iteration; nothing is ever reported.
          state_d  = ST_FREE;
          cnt_d    = 6'd0;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q < CNT_LAST) begin
          if (diff[W]) begin
            dvd_d = {dvd_q[2*W-1:0], 1'b0};
          end else begin
            dvd_d = {diff[W-1:0], dvd_q[W-1:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
          cnt_d    = 6'd0;
          state_d  = ST_END;
        end
      end

      ST_END: begin
        // Result is held for as long as EX keeps requesting; flush is ignored.
        if (!start_i) begin
          state_d  = ST_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FREE;
      cnt_q    <= 6'd0;
      dvd_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // Operand magnitude and signs are only meaningful once loaded from FREE.
  always_ff @(posedge clk) begin
    dsr_q <= dsr_d;
    s1_q  <= s1_d;
    s2_q  <= s2_d;
    sgn_q <= sgn_d;
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
